// File: rtl/hood_pkg.sv
// Shared hood definitions: mode encodings from the mode FSM and the
// hurricane scheduler state encoding.
package hood_pkg;

  localparam logic [2:0] MODE_STANDBY = 3'b000;
  localparam logic [2:0] MODE_1       = 3'b001;
  localparam logic [2:0] MODE_2       = 3'b010;
  localparam logic [2:0] MODE_3       = 3'b011;
  localparam logic [2:0] MODE_CLEAN   = 3'b100;

  typedef enum logic [2:0] {
    SCH_OFF    = 3'd0,
    SCH_READY  = 3'd1,
    SCH_RUN    = 3'd2,
    SCH_EXIT   = 3'd3,
    SCH_LOCKED = 3'd4
  } sched_state_t;

endpackage

// File: rtl/sec_tick.sv
// One-second prescaler: while enabled, pulses tick for one cycle every
// CLK_HZ cycles. clear returns the count to zero and wins over enable.
module sec_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // tick must not depend on clear: callers derive clear from the tick's effect
  assign tick = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hurricane_scheduler.sv
// Hurricane (mode 3) sequencer: one run per power session, countdown in
// seconds, and the gear-2/standby return choice latched from the menu button.
module hurricane_scheduler #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int HURRICANE_S = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       machine_state,
  input  logic [2:0] mode_state,
  input  logic       menu_btn,
  output logic       hurricane_mode_enabled,
  output logic       return_state,
  output logic [7:0] countdown,
  output logic       hurricane_used
);

  import hood_pkg::*;

  localparam logic [7:0] RUN_S = 8'(HURRICANE_S);

  sched_state_t state_q, state_d;
  logic       menu_prev_q, menu_prev_d;
  logic       latch_q, latch_d;
  logic       enabled_q, enabled_d;
  logic       return_state_q, return_state_d;
  logic       used_q, used_d;
  logic [7:0] countdown_q, countdown_d;

  logic menu_edge;
  logic mode3;
  logic tick;
  logic in_run;
  logic prescale_clear;

  assign menu_edge = menu_btn & ~menu_prev_q;
  assign mode3     = (mode_state == MODE_3);
  assign in_run    = (state_q == SCH_RUN);

  // Zero the prescaler on every cycle that is not a continuing RUN cycle,
  // so each run starts its first second from a clean count.
  assign prescale_clear = !in_run || (state_d != SCH_RUN);

  sec_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (prescale_clear),
    .enable(in_run),
    .tick  (tick)
  );

  always_comb begin
    state_d        = state_q;
    latch_d        = latch_q;
    return_state_d = return_state_q;
    countdown_d    = countdown_q;
    menu_prev_d    = menu_btn;

    if (!machine_state) begin
      state_d        = SCH_OFF;
      latch_d        = 1'b0;
      return_state_d = 1'b0;
      countdown_d    = 8'd0;
    end else begin
      case (state_q)
        SCH_OFF: state_d = SCH_READY;
        SCH_READY: begin
          if (mode3) begin
            state_d        = SCH_RUN;
            countdown_d    = RUN_S;
            latch_d        = 1'b0;
            return_state_d = 1'b0;
          end
        end
        SCH_RUN: begin
          // Abort beats expiry, expiry and menu edge in the same cycle both apply
          if (!mode3) begin
            state_d     = SCH_LOCKED;
            countdown_d = 8'd0;
          end else begin
            latch_d = latch_q | menu_edge;
            if (tick) begin
              countdown_d = (countdown_q != 8'd0) ? countdown_q - 8'd1 : 8'd0;
              if (countdown_q == 8'd1) begin
                state_d        = SCH_EXIT;
                return_state_d = latch_q | menu_edge;
              end
            end
          end
        end
        SCH_EXIT: begin
          if (!mode3) state_d = SCH_LOCKED;
        end
        SCH_LOCKED: state_d = state_q;
        default:    state_d = SCH_OFF;
      endcase
    end

    enabled_d = (state_d == SCH_READY) || (state_d == SCH_RUN);
    used_d    = (state_d == SCH_RUN) || (state_d == SCH_EXIT) || (state_d == SCH_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= SCH_OFF;
      menu_prev_q    <= 1'b0;
      latch_q        <= 1'b0;
      enabled_q      <= 1'b0;
      return_state_q <= 1'b0;
      used_q         <= 1'b0;
      countdown_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      menu_prev_q    <= menu_prev_d;
      latch_q        <= latch_d;
      enabled_q      <= enabled_d;
      return_state_q <= return_state_d;
      used_q         <= used_d;
      countdown_q    <= countdown_d;
    end
  end

  assign hurricane_mode_enabled = enabled_q;
  assign return_state           = return_state_q;
  assign countdown              = countdown_q;
  assign hurricane_used         = used_q;

endmodule

// File: tb/tb_hurricane_scheduler.sv
// Bench for hurricane_scheduler with CLK_HZ=10, HURRICANE_S=3: directed
// scenarios plus a randomized soak against a session/elapsed-time model.
module tb_hurricane_scheduler;

  localparam int CLK_HZ = 10;
  localparam int HS     = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       machine_state;
  logic [2:0] mode_state;
  logic       menu_btn;
  logic       en;
  logic       ret;
  logic [7:0] cd;
  logic       used;
  logic [10:0] dut_vec;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: power session, run in progress, run finished-waiting,
  // cycles elapsed since run start, and the menu choice.
  bit m_on, m_run, m_exit, m_used, m_latch, m_ret, m_prev;
  int m_el;

  hurricane_scheduler #(
    .CLK_HZ     (CLK_HZ),
    .HURRICANE_S(HS)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .machine_state         (machine_state),
    .mode_state            (mode_state),
    .menu_btn              (menu_btn),
    .hurricane_mode_enabled(en),
    .return_state          (ret),
    .countdown             (cd),
    .hurricane_used        (used)
  );

  assign dut_vec = {en, ret, used, cd};

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached (got running, need finished)");
    $fatal(1, "watchdog");
  end

  task automatic model_update();
    bit edge_now;
    if (rst) begin
      m_on = 0; m_run = 0; m_exit = 0; m_used = 0;
      m_latch = 0; m_ret = 0; m_el = 0; m_prev = 0;
    end else begin
      edge_now = menu_btn && !m_prev;
      if (!machine_state) begin
        m_on = 0; m_run = 0; m_exit = 0; m_used = 0;
        m_latch = 0; m_ret = 0; m_el = 0;
      end else if (!m_on) begin
        m_on = 1;
      end else if (m_run) begin
        if (mode_state != 3'd3) begin
          m_run = 0;
        end else begin
          m_el++;
          m_latch = m_latch | edge_now;
          if (m_el == HS * CLK_HZ) begin
            m_run  = 0;
            m_exit = 1;
            m_ret  = m_latch;
          end
        end
      end else if (m_exit) begin
        if (mode_state != 3'd3) m_exit = 0;
      end else if (!m_used && mode_state == 3'd3) begin
        m_run = 1; m_used = 1; m_el = 0; m_latch = 0; m_ret = 0;
      end
      m_prev = menu_btn;
    end
  endtask

  function automatic logic [10:0] exp_vec();
    logic       e;
    logic [7:0] c;
    e = m_on && (m_run || !m_used);
    c = m_run ? 8'(HS - m_el / CLK_HZ) : 8'd0;
    return {e, m_ret, m_used, c};
  endfunction

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; machine_state = 1'b0; mode_state = 3'd0; menu_btn = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic enter_run();
    machine_state = 1'b1; mode_state = 3'd0;
    step();
    mode_state = 3'd3;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; machine_state = 1'b1; mode_state = 3'd3; menu_btn = 1'b1;
    step(); step();
    n_cmp++;
    if (dut_vec !== 11'd0) begin
      n_fail++; $display("FAIL reset_outputs got=%h need=%h", dut_vec, 11'd0);
    end
    rst = 1'b0; machine_state = 1'b0; mode_state = 3'd0; menu_btn = 1'b0;
    step();
    n_cmp++;
    if (dut_vec !== 11'd0) begin
      n_fail++; $display("FAIL off_outputs got=%h need=%h", dut_vec, 11'd0);
    end
  endtask

  task automatic test_basic_run();
    int hi;
    int seq[$];
    logic [7:0] last;
    do_reset();
    machine_state = 1'b1;
    step();
    n_cmp++;
    if ({en, used} !== 2'b10) begin
      n_fail++; $display("FAIL basic_ready en/used got=%b need=10", {en, used});
    end
    mode_state = 3'd3;
    step();
    n_cmp++;
    if ({en, used, cd} !== {1'b1, 1'b1, 8'(HS)}) begin
      n_fail++; $display("FAIL basic_entry got en=%b used=%b cd=%0d need 1 1 %0d", en, used, cd, HS);
    end
    hi = (en === 1'b1) ? 1 : 0;
    seq.push_back(int'(cd));
    last = cd;
    for (int i = 1; i <= 40; i++) begin
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL basic_model cyc=%0d got=%h need=%h", i, dut_vec, exp_vec());
      end
      if (en === 1'b1) hi++;
      if (cd !== last) begin
        seq.push_back(int'(cd));
        last = cd;
      end
    end
    n_cmp++;
    if (hi != HS * CLK_HZ) begin
      n_fail++; $display("FAIL basic_enabled_cycles got=%0d need=%0d", hi, HS * CLK_HZ);
    end
    n_cmp++;
    if (seq.size() != HS + 1) begin
      n_fail++; $display("FAIL basic_countdown_len got=%0d need=%0d", seq.size(), HS + 1);
    end else begin
      for (int k = 0; k <= HS; k++) begin
        n_cmp++;
        if (seq[k] != HS - k) begin
          n_fail++; $display("FAIL basic_countdown_seq[%0d] got=%0d need=%0d", k, seq[k], HS - k);
        end
      end
    end
    n_cmp++;
    if (ret !== 1'b0) begin
      n_fail++; $display("FAIL basic_return got=%b need=0", ret);
    end
  endtask

  task automatic test_return_gear2();
    bit fell;
    do_reset();
    enter_run();
    for (int i = 1; i < 12; i++) step();
    menu_btn = 1'b1;
    step();
    menu_btn = 1'b0;
    fell = 0;
    for (int i = 0; i < 40 && !fell; i++) begin
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL gear2_model cyc=%0d got=%h need=%h", i, dut_vec, exp_vec());
      end
      if (en === 1'b0) fell = 1;
    end
    n_cmp++;
    if (!fell) begin
      n_fail++; $display("FAIL gear2_timeout enabled got=1 need=0 within 40 cycles");
    end
    n_cmp++;
    if (ret !== 1'b1) begin
      n_fail++; $display("FAIL gear2_return got=%b need=1", ret);
    end
    mode_state = 3'd2;
    step(); step();
    n_cmp++;
    if ({en, ret, used, cd} !== {1'b0, 1'b1, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL gear2_locked got=%h need=%h", dut_vec, {1'b0, 1'b1, 1'b1, 8'd0});
    end
  endtask

  task automatic test_one_run_per_session();
    mode_state = 3'd3;
    repeat (5) step();
    n_cmp++;
    if ({en, used} !== 2'b01) begin
      n_fail++; $display("FAIL session_rerun en/used got=%b need=01", {en, used});
    end
    machine_state = 1'b0;
    step();
    n_cmp++;
    if (dut_vec !== 11'd0) begin
      n_fail++; $display("FAIL session_off got=%h need=%h", dut_vec, 11'd0);
    end
    machine_state = 1'b1; mode_state = 3'd0;
    step();
    n_cmp++;
    if ({en, used} !== 2'b10) begin
      n_fail++; $display("FAIL session_rearm en/used got=%b need=10", {en, used});
    end
  endtask

  task automatic test_power_off_mid_run();
    int pc;
    for (int trial = 0; trial < 3; trial++) begin
      pc = (trial == 0) ? 15 : int'($urandom_range(1, 29));
      do_reset();
      enter_run();
      for (int i = 1; i < pc; i++) step();
      machine_state = 1'b0;
      step();
      n_cmp++;
      if ({en, used, cd} !== 10'd0) begin
        n_fail++; $display("FAIL poweroff_run at=%0d got en=%b used=%b cd=%0d need 0 0 0", pc, en, used, cd);
      end
      machine_state = 1'b1; mode_state = 3'd0;
      step();
      n_cmp++;
      if ({en, used, cd} !== {1'b1, 1'b0, 8'd0}) begin
        n_fail++; $display("FAIL poweroff_ready at=%0d got en=%b used=%b cd=%0d need 1 0 0", pc, en, used, cd);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit fell;
    int k;
    do_reset();
    enter_run();
    for (int i = 1; i < HS * CLK_HZ; i++) step();
    menu_btn = 1'b1;
    step();
    n_cmp++;
    if ({en, ret} !== 2'b01) begin
      n_fail++; $display("FAIL simul_final_tick en/ret got=%b need=01", {en, ret});
    end
    menu_btn = 1'b0; mode_state = 3'd2;
    step();
    machine_state = 1'b0;
    step();
    enter_run();
    k = int'($urandom_range(3, 20));
    repeat (k) step();
    menu_btn = 1'b1;
    step();
    rst = 1'b1;
    step();
    n_cmp++;
    if (dut_vec !== 11'd0) begin
      n_fail++; $display("FAIL simul_rst_midrun got=%h need=%h", dut_vec, 11'd0);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if ({en, used} !== 2'b10) begin
      n_fail++; $display("FAIL simul_rst_ready en/used got=%b need=10", {en, used});
    end
    step();
    n_cmp++;
    if ({en, used, cd} !== {1'b1, 1'b1, 8'(HS)}) begin
      n_fail++; $display("FAIL simul_rerun got=%h need=%h", dut_vec, {1'b1, 1'b0, 1'b1, 8'(HS)});
    end
    fell = 0;
    for (int i = 0; i < 40 && !fell; i++) begin
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL simul_model cyc=%0d got=%h need=%h", i, dut_vec, exp_vec());
      end
      if (en === 1'b0) fell = 1;
    end
    n_cmp++;
    if (!fell || ret !== 1'b0) begin
      n_fail++; $display("FAIL simul_held_menu fell=%0d ret got=%b need fell=1 ret=0", fell, ret);
    end
    menu_btn = 1'b0;
  endtask

  task automatic test_held_and_abort();
    bit fell;
    int k;
    do_reset();
    machine_state = 1'b1; menu_btn = 1'b1;
    step(); step();
    mode_state = 3'd3;
    step();
    fell = 0;
    for (int i = 0; i < 40 && !fell; i++) begin
      step();
      if (en === 1'b0) fell = 1;
    end
    n_cmp++;
    if (!fell || ret !== 1'b0) begin
      n_fail++; $display("FAIL held_return fell=%0d ret got=%b need fell=1 ret=0", fell, ret);
    end
    menu_btn = 1'b0; machine_state = 1'b0;
    step();
    enter_run();
    k = int'($urandom_range(1, 28));
    repeat (k) step();
    mode_state = 3'd1;
    step();
    n_cmp++;
    if ({en, used, cd} !== {1'b0, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL abort_locked at=%0d got en=%b used=%b cd=%0d need 0 1 0", k, en, used, cd);
    end
    mode_state = 3'd3;
    step(); step();
    n_cmp++;
    if ({en, used, cd} !== {1'b0, 1'b1, 8'd0}) begin
      n_fail++; $display("FAIL abort_stays_locked got en=%b used=%b cd=%0d need 0 1 0", en, used, cd);
    end
  endtask

  task automatic test_random_soak();
    do_reset();
    machine_state = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 299) == 0);
      machine_state = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 39) == 0) mode_state = 3'($urandom_range(0, 4));
      else if ($urandom_range(0, 19) == 0) mode_state = 3'd3;
      if ($urandom_range(0, 5) == 0) menu_btn = ~menu_btn;
      step();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_model cyc=%0d got=%h need=%h", i, dut_vec, exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; machine_state = 1'b0; mode_state = 3'd0; menu_btn = 1'b0;
    m_on = 0; m_run = 0; m_exit = 0; m_used = 0;
    m_latch = 0; m_ret = 0; m_prev = 0; m_el = 0;
    test_reset();
    test_basic_run();
    test_return_gear2();
    test_one_run_per_session();
    test_power_off_mid_run();
    test_simultaneous();
    test_held_and_abort();
    test_random_soak();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
